// File: rtl/change_dispense_sequencer_if.sv
// Coin-return bus: request side from the balance logic, eject handshake
// to the coin hopper, and the per-dispense status/count reporting.
interface change_dispense_sequencer_if #(
  parameter int TUBE_W = 5
);
  logic              start;
  logic [8:0]        amount;
  logic [TUBE_W-1:0] tube_q;
  logic [TUBE_W-1:0] tube_d;
  logic [TUBE_W-1:0] tube_n;
  logic              eject_req;
  logic [1:0]        eject_sel;
  logic              eject_ack;
  logic              busy;
  logic              done;
  logic              short;
  logic              fault;
  logic [8:0]        shortfall;
  logic [TUBE_W-1:0] quarter_o;
  logic [TUBE_W-1:0] dime_o;
  logic [TUBE_W-1:0] nickel_o;

  // Environment side: balance logic plus hopper.
  modport master (
    output start, amount, tube_q, tube_d, tube_n, eject_ack,
    input  eject_req, eject_sel, busy, done, short, fault, shortfall,
           quarter_o, dime_o, nickel_o
  );

  // Sequencer side.
  modport slave (
    input  start, amount, tube_q, tube_d, tube_n, eject_ack,
    output eject_req, eject_sel, busy, done, short, fault, shortfall,
           quarter_o, dime_o, nickel_o
  );
endinterface

// File: rtl/change_dispense_sequencer.sv
// Change dispense sequencer: greedy, inventory-aware coin return with one
// eject request at a time, an ack timeout and a solenoid recovery gap.
//
//   state  | meaning
//   IDLE   | waiting for start; status of last dispense held
//   SELECT | pick largest usable coin for remaining amount
//   EJECT  | eject_req high, waiting for hopper ack (timed)
//   GAP    | solenoid recovery, eject_req low
//   DONE   | one-cycle done pulse, then back to IDLE
module change_dispense_sequencer #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000,
  parameter int TUBE_W      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  change_dispense_sequencer_if.slave    bus
);

  localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_N    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_Q    = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        remaining;
  logic [TUBE_W-1:0] q_cp, d_cp, n_cp;
  logic [TUBE_W-1:0] q_cnt, d_cnt, n_cnt;
  logic [TMR_W-1:0]  timer;
  logic [1:0]        sel_q;
  logic [1:0]        pick;
  logic [8:0]        coin_val;
  logic              short_q, fault_q;
  logic [8:0]        shortfall_q;

  // Greedy coin choice, largest denomination first, no backtracking.
  always_comb begin
    pick = SEL_NONE;
    if (remaining >= 9'd25 && q_cp != '0)
      pick = SEL_Q;
    else if (remaining >= 9'd10 && d_cp != '0)
      pick = SEL_D;
    else if (remaining >= 9'd5 && n_cp != '0)
      pick = SEL_N;
  end

  // Cent value of the coin currently being ejected.
  always_comb begin
    coin_val = 9'd0;
    case (sel_q)
      SEL_Q:   coin_val = 9'd25;
      SEL_D:   coin_val = 9'd10;
      SEL_N:   coin_val = 9'd5;
      default: coin_val = 9'd0;
    endcase
  end

  // State register; reset forces IDLE so eject_req drops immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; ack beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SELECT;
      SELECT:  state_d = (pick != SEL_NONE) ? EJECT : DONE;
      EJECT: begin
        if (bus.eject_ack)       state_d = GAP;
        else if (timer == ACK_LAST) state_d = DONE;
      end
      GAP:     if (timer == GAP_LAST) state_d = SELECT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: amount/tube capture, coin accounting, timer and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining   <= '0;
      q_cp        <= '0;
      d_cp        <= '0;
      n_cp        <= '0;
      q_cnt       <= '0;
      d_cnt       <= '0;
      n_cnt       <= '0;
      timer       <= '0;
      sel_q       <= SEL_NONE;
      short_q     <= 1'b0;
      fault_q     <= 1'b0;
      shortfall_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            remaining   <= bus.amount;
            q_cp        <= bus.tube_q;
            d_cp        <= bus.tube_d;
            n_cp        <= bus.tube_n;
            q_cnt       <= '0;
            d_cnt       <= '0;
            n_cnt       <= '0;
            timer       <= '0;
            short_q     <= 1'b0;
            fault_q     <= 1'b0;
            shortfall_q <= '0;
          end
        end
        SELECT: begin
          timer <= '0;
          if (pick != SEL_NONE) begin
            sel_q <= pick;
          end else if (remaining != 9'd0) begin
            short_q     <= 1'b1;
            shortfall_q <= remaining;
          end
        end
        EJECT: begin
          if (bus.eject_ack) begin
            // Selection guaranteed remaining >= coin_val and copy > 0.
            remaining <= remaining - coin_val;
            timer     <= '0;
            case (sel_q)
              SEL_Q: begin
                q_cp  <= q_cp - TUBE_W'(1);
                q_cnt <= q_cnt + TUBE_W'(1);
              end
              SEL_D: begin
                d_cp  <= d_cp - TUBE_W'(1);
                d_cnt <= d_cnt + TUBE_W'(1);
              end
              SEL_N: begin
                n_cp  <= n_cp - TUBE_W'(1);
                n_cnt <= n_cnt + TUBE_W'(1);
              end
              default: ;
            endcase
          end else if (timer == ACK_LAST) begin
            fault_q     <= 1'b1;
            shortfall_q <= remaining;
            timer       <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        GAP:     timer <= timer + TMR_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.eject_req = (state_q == EJECT);
  assign bus.eject_sel = (state_q == EJECT || state_q == GAP) ? sel_q : SEL_NONE;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.short     = short_q;
  assign bus.fault     = fault_q;
  assign bus.shortfall = shortfall_q;
  assign bus.quarter_o = q_cnt;
  assign bus.dime_o    = d_cnt;
  assign bus.nickel_o  = n_cnt;

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Scoreboard bench: stimulus pushes expected coin selects and end-of-dispense
// results; a negedge monitor pops and compares as the DUT presents them.
module tb_change_dispense_sequencer;
  localparam int GAP_CYCLES  = 4;
  localparam int ACK_TIMEOUT = 1000;
  localparam int TUBE_W      = 5;

  typedef struct {
    int shrt;
    int flt;
    int sf;
    int q;
    int d;
    int n;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic h_ack = 1'b0;
  logic x_ack = 1'b0;
  bit   hop_en = 1'b1;
  int   ack_delay = 2;
  int   hop_cnt = 0;

  int   errors = 0;
  int   checks = 0;

  int   coin_q[$];
  res_t res_q[$];

  bit   prev_req = 1'b0;
  bit   have_prev = 1'b0;
  int   low_run = 0;
  int   high_run = 0;
  int   last_high = 0;

  change_dispense_sequencer_if #(.TUBE_W(TUBE_W)) ifc ();

  change_dispense_sequencer #(
    .GAP_CYCLES (GAP_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TUBE_W     (TUBE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  assign ifc.eject_ack = h_ack | x_ack;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hopper model: acks ack_delay cycles after eject_req rises.
  always @(negedge clk) begin
    if (!rst || !ifc.eject_req) begin
      hop_cnt = 0;
      h_ack   = 1'b0;
    end else if (hop_en) begin
      hop_cnt++;
      h_ack = (hop_cnt >= ack_delay);
    end
  end

  // Monitor: coin selects, recovery gap, req-high length, done results.
  always @(negedge clk) begin
    if (!rst) begin
      prev_req  = 1'b0;
      have_prev = 1'b0;
      low_run   = 0;
      high_run  = 0;
    end else begin
      if (ifc.eject_req && !prev_req) begin
        if (coin_q.size() == 0) check("coin_sel_extra", int'(ifc.eject_sel), 0);
        else                    check("coin_sel", int'(ifc.eject_sel), coin_q.pop_front());
        // Low stretch between coins covers the GAP cycles plus the SELECT cycle.
        if (have_prev) check("gap_low_cycles", low_run, GAP_CYCLES + 1);
        have_prev = 1'b1;
        low_run   = 0;
        high_run  = 0;
      end
      if (ifc.eject_req) high_run++;
      else if (prev_req) last_high = high_run;
      if (!ifc.eject_req && have_prev && !ifc.done) low_run++;
      if (ifc.done) begin
        if (res_q.size() == 0) begin
          check("done_extra", 1, 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("short",     int'(ifc.short),     r.shrt);
          check("fault",     int'(ifc.fault),     r.flt);
          check("shortfall", int'(ifc.shortfall), r.sf);
          check("quarter_o", int'(ifc.quarter_o), r.q);
          check("dime_o",    int'(ifc.dime_o),    r.d);
          check("nickel_o",  int'(ifc.nickel_o),  r.n);
          check("done_sel_idle", int'(ifc.eject_sel), 0);
        end
        have_prev = 1'b0;
        low_run   = 0;
      end
      prev_req = ifc.eject_req;
    end
  end

  task automatic push_res(input int shrt, input int flt, input int sf,
                          input int q, input int d, input int n);
    res_t r;
    r.shrt = shrt; r.flt = flt; r.sf = sf; r.q = q; r.d = d; r.n = n;
    res_q.push_back(r);
  endtask

  task automatic drive_start(input int amt, input int q, input int d, input int n);
    @(posedge clk); #1;
    ifc.start  = 1'b1;
    ifc.amount = 9'(amt);
    ifc.tube_q = TUBE_W'(q);
    ifc.tube_d = TUBE_W'(d);
    ifc.tube_n = TUBE_W'(n);
    @(posedge clk); #1;
    ifc.start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!ifc.busy) ok = 1'b1;
    end
    if (!ok) check("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_req(input bit lvl, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ifc.eject_req == lvl) ok = 1'b1;
    end
    if (!ok) check("wait_req_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ifc.start  = 1'b0;
    ifc.amount = '0;
    ifc.tube_q = '0;
    ifc.tube_d = '0;
    ifc.tube_n = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      int'(ifc.busy), 0);
    check("rst_req",       int'(ifc.eject_req), 0);
    check("rst_sel",       int'(ifc.eject_sel), 0);
    check("rst_done",      int'(ifc.done), 0);
    check("rst_short",     int'(ifc.short), 0);
    check("rst_fault",     int'(ifc.fault), 0);
    check("rst_shortfall", int'(ifc.shortfall), 0);
    check("rst_counts",    int'(ifc.quarter_o) + int'(ifc.dime_o) + int'(ifc.nickel_o), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 90c with full tubes: Q Q Q D N; busy start ignored; GAP ack ignored.
    coin_q.push_back(3); coin_q.push_back(3); coin_q.push_back(3);
    coin_q.push_back(2); coin_q.push_back(1);
    push_res(0, 0, 0, 3, 1, 1);
    drive_start(90, 5, 5, 5);
    wait_req(1'b1, 20);
    drive_start(5, 0, 0, 0);
    wait_req(1'b0, 20);
    @(posedge clk); #1;
    x_ack = 1'b1;
    @(posedge clk); #1;
    x_ack = 1'b0;
    @(negedge clk);
    check("gap_ack_no_count", int'(ifc.quarter_o), 1);
    wait_idle(400);

    // 30c, q=1 d=3 n=0: greedy takes the quarter and strands 5c.
    coin_q.push_back(3);
    push_res(1, 0, 5, 1, 0, 0);
    drive_start(30, 1, 3, 0);
    wait_idle(200);

    // 47c, all tubes 10: Q D D, 2c short.
    coin_q.push_back(3); coin_q.push_back(2); coin_q.push_back(2);
    push_res(1, 0, 2, 1, 2, 0);
    drive_start(47, 10, 10, 10);
    wait_idle(300);

    // 0c: straight to DONE.
    push_res(0, 0, 0, 0, 0, 0);
    drive_start(0, 5, 5, 5);
    wait_idle(20);

    // 7c: one nickel, 2c residual.
    coin_q.push_back(1);
    push_res(1, 0, 2, 0, 0, 1);
    drive_start(7, 5, 5, 5);
    wait_idle(100);

    // 25c with a dead hopper: ack timeout.
    hop_en = 1'b0;
    coin_q.push_back(3);
    push_res(0, 1, 25, 0, 0, 0);
    drive_start(25, 1, 1, 1);
    wait_idle(ACK_TIMEOUT + 100);
    check("timeout_req_high", last_high, ACK_TIMEOUT);
    hop_en = 1'b1;

    // 50c, reset during the second EJECT.
    coin_q.push_back(3); coin_q.push_back(3);
    drive_start(50, 5, 5, 5);
    wait_req(1'b1, 20);
    wait_req(1'b0, 20);
    wait_req(1'b1, 20);
    check("pre_rst_quarter", int'(ifc.quarter_o), 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req",     int'(ifc.eject_req), 0);
    check("mid_rst_busy",    int'(ifc.busy), 0);
    check("mid_rst_quarter", int'(ifc.quarter_o), 0);
    check("mid_rst_sel",     int'(ifc.eject_sel), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Clean 10c after reset: one dime.
    coin_q.push_back(2);
    push_res(0, 0, 0, 0, 1, 0);
    drive_start(10, 5, 5, 5);
    wait_idle(100);

    repeat (3) @(negedge clk);
    check("coin_queue_empty",   coin_q.size(), 0);
    check("result_queue_empty", res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
